// File: rtl/rapid_data_bus_bridge.sv
// Bridge from the CPU memory stage to a valid/ready bus with a separate read-response channel.
// Optional bus wait timeout is enabled by defining RAPID_BUS_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for i_cpu_req; request fields latched on acceptance
// REQ    | o_bus_valid high until i_bus_ready
// WAIT_R | read accepted, waiting for i_bus_rvalid
// DONE   | one-cycle o_cpu_ready pulse (o_cpu_err qualifies it)
module rapid_data_bus_bridge #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_cpu_req,
    input  logic [XLEN-1:0] i_cpu_addr,
    input  logic [XLEN-1:0] i_cpu_wdata,
    input  logic [3:0]      i_cpu_we,
    output logic [XLEN-1:0] o_cpu_rdata,
    output logic            o_cpu_ready,
    output logic            o_cpu_err,
    output logic            o_bus_valid,
    input  logic            i_bus_ready,
    output logic [XLEN-1:0] o_bus_addr,
    output logic [XLEN-1:0] o_bus_wdata,
    output logic [3:0]      o_bus_we,
    input  logic            i_bus_rvalid,
    input  logic [XLEN-1:0] i_bus_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REQ    = 2'd1;
    localparam logic [1:0] WAIT_R = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      we_q, we_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    // Byte offset is carried by the enables, so the low address bits are dropped.
    logic unused_inputs;
    assign unused_inputs = (^i_cpu_addr[1:0]) ^ (TIMEOUT_CYCLES == 0);

`ifdef RAPID_BUS_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        expired;

    assign expired   = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign o_cpu_err = err_q;
`else
    assign o_cpu_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
`ifdef RAPID_BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (i_cpu_req) begin
                    addr_d  = {i_cpu_addr[XLEN-1:2], 2'b00};
                    wdata_d = i_cpu_wdata;
                    we_d    = i_cpu_we;
                    state_d = REQ;
`ifdef RAPID_BUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ: begin
`ifdef RAPID_BUS_TIMEOUT_EN
                cnt_d = cnt_q + 16'd1;
`endif
                if (i_bus_ready) begin
                    if (we_q != 4'b0000) begin
                        state_d = DONE;
                    end else if (i_bus_rvalid) begin
                        rdata_d = i_bus_rdata;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_R;
                    end
                end
`ifdef RAPID_BUS_TIMEOUT_EN
                else if (expired) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                    if (we_q == 4'b0000) rdata_d = '0;
                end
`endif
            end
            WAIT_R: begin
`ifdef RAPID_BUS_TIMEOUT_EN
                cnt_d = cnt_q + 16'd1;
`endif
                if (i_bus_rvalid) begin
                    rdata_d = i_bus_rdata;
                    state_d = DONE;
                end
`ifdef RAPID_BUS_TIMEOUT_EN
                else if (expired) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef RAPID_BUS_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    assign o_bus_valid = (state_q == REQ);
    assign o_cpu_ready = (state_q == DONE);
    assign o_bus_addr  = addr_q;
    assign o_bus_wdata = wdata_q;
    assign o_bus_we    = we_q;
    assign o_cpu_rdata = rdata_q;

endmodule
